// File: rtl/datamover_cmd_sched.sv
// Round-robin sharing of one DataMover CMD/STS pair; jobs split into CHUNK-aligned commands.
// Accept->first cmd 2 cycles, last status->done 2 cycles; tvalid gated by outstanding limit, STS always ready.
module datamover_cmd_sched #(
  parameter int NREQ            = 4,
  parameter int CHUNK           = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_len,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [3:0]           grant_id,
  output logic [103:0]         S_AXIS_CMD_tdata,
  output logic                 S_AXIS_CMD_tvalid,
  input  logic                 S_AXIS_CMD_tready,
  input  logic [7:0]           M_AXIS_STS_tdata,
  input  logic                 M_AXIS_STS_tvalid,
  output logic                 M_AXIS_STS_tready,
  input  logic                 M_AXIS_STS_tlast
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] CMASK = 32'(CHUNK - 1);

  state_t       r_state, w_state_nxt;
  logic [63:0]  r_addr;
  logic [31:0]  r_rem;
  logic [3:0]   r_out;
  logic [3:0]   r_grant_id;
  logic [3:0]   r_rr_ptr;
  logic         r_err;

  logic [NREQ-1:0] w_hi;
  logic            w_pick_vld;
  logic [3:0]      w_pick;
  logic [63:0]     w_sel_addr;
  logic [31:0]     w_sel_len;
  logic [31:0]     w_room;
  logic [31:0]     w_chunk;
  logic            w_last;
  logic            w_cmd_vld;
  logic            w_cmd_hs;
  logic            w_sts;
  logic            w_sts_bad;
  logic            w_unused_tlast;

  // Requesters at or after the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    w_hi       = '0;
    w_pick     = '0;
    w_pick_vld = |req_valid;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NREQ; i++) w_hi[i] = req_valid[i] && (4'(i) >= r_rr_ptr);
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) w_pick = 4'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (w_hi[i]) w_pick = 4'(i);
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == 4'(i)) begin
        w_sel_addr = req_addr[i*64 +: 64];
        w_sel_len  = req_len[i*32 +: 32];
      end
    end
  end

  assign w_room    = 32'(CHUNK) - (r_addr[31:0] & CMASK);
  assign w_chunk   = (r_rem < w_room) ? r_rem : w_room;
  assign w_last    = (r_rem <= w_room);
  assign w_cmd_vld = (r_state == S_ISSUE) && (r_rem != 32'd0) && (r_out < 4'(MAX_OUTSTANDING));
  assign w_cmd_hs  = w_cmd_vld && S_AXIS_CMD_tready;
  // A status with nothing outstanding cannot belong to this job and is discarded.
  assign w_sts     = M_AXIS_STS_tvalid && (r_state != S_IDLE) && (r_out != 4'd0);
  assign w_sts_bad = !M_AXIS_STS_tdata[7] || (|M_AXIS_STS_tdata[6:4]) ||
                     (M_AXIS_STS_tdata[3:0] != r_grant_id);
  assign w_unused_tlast = M_AXIS_STS_tlast;

  assign S_AXIS_CMD_tvalid = w_cmd_vld;
  assign S_AXIS_CMD_tdata  = {4'h0, r_grant_id, r_addr, 1'b0, w_last, 6'h00, 1'b1, w_chunk[22:0]};
  assign M_AXIS_STS_tready = 1'b1;
  assign grant_id          = r_grant_id;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    done        = '0;
    err         = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_GRANT;
          for (int i = 0; i < NREQ; i++) req_ready[i] = (w_pick == 4'(i));
        end
      end
      S_GRANT: begin
        busy        = 1'b1;
        w_state_nxt = (r_rem == 32'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (w_cmd_hs && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_out == 4'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        for (int i = 0; i < NREQ; i++) begin
          done[i] = (r_grant_id == 4'(i));
          err[i]  = (r_grant_id == 4'(i)) && r_err;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_out      <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_pick_vld) begin
        r_addr     <= w_sel_addr;
        r_rem      <= w_sel_len;
        r_grant_id <= w_pick;
      end else if (w_cmd_hs) begin
        r_addr <= r_addr + 64'(w_chunk);
        r_rem  <= r_rem - w_chunk;
      end
      if (w_cmd_hs && !w_sts)      r_out <= r_out + 4'd1;
      else if (!w_cmd_hs && w_sts) r_out <= r_out - 4'd1;
      if (r_state == S_DONE) begin
        r_err    <= 1'b0;
        r_rr_ptr <= (r_grant_id == 4'(NREQ - 1)) ? 4'd0 : r_grant_id + 4'd1;
      end else if (w_sts && w_sts_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_datamover_cmd_sched.sv
// Directed bench for datamover_cmd_sched: inputs change 2ns after posedge, outputs sampled on negedge or at posedge+2.
module tb_datamover_cmd_sched;
  localparam int NREQ = 4;

  logic                axis_clk = 1'b0;
  logic                axis_rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*64-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_len;
  logic [NREQ-1:0]     done;
  logic [NREQ-1:0]     err;
  logic                busy;
  logic [3:0]          grant_id;
  logic [103:0]        cmd_tdata;
  logic                cmd_tvalid;
  logic                cmd_tready;
  logic [7:0]          sts_tdata;
  logic                sts_tvalid;
  logic                sts_tready;
  logic                sts_tlast;

  always #5 axis_clk = ~axis_clk;

  datamover_cmd_sched #(.NREQ(NREQ), .CHUNK(4096), .MAX_OUTSTANDING(4)) u_dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .done(done), .err(err), .busy(busy), .grant_id(grant_id),
    .S_AXIS_CMD_tdata(cmd_tdata), .S_AXIS_CMD_tvalid(cmd_tvalid), .S_AXIS_CMD_tready(cmd_tready),
    .M_AXIS_STS_tdata(sts_tdata), .M_AXIS_STS_tvalid(sts_tvalid), .M_AXIS_STS_tready(sts_tready),
    .M_AXIS_STS_tlast(sts_tlast)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [103:0]    cmd_q[$];
  logic [NREQ-1:0] acc_q[$];
  int              acc_cyc_q[$];
  logic [NREQ-1:0] done_q[$];
  logic [NREQ-1:0] derr_q[$];
  int              done_cyc_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mkcmd(input logic [22:0] btt, input logic eof,
                                         input logic [63:0] a, input logic [3:0] tag);
    return {4'h0, tag, a, 1'b0, eof, 6'h00, 1'b1, btt};
  endfunction

  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(negedge axis_clk) begin
    if (!axis_rst) begin
      if (cmd_tvalid && cmd_tready) cmd_q.push_back(cmd_tdata);
      if (|req_ready) begin
        check("rdy_onehot", 128'($onehot(req_ready)), 128'(1));
        acc_q.push_back(req_ready);
        acc_cyc_q.push_back(cyc);
      end
      if (|done) begin
        done_q.push_back(done);
        derr_q.push_back(err);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic start_job(input int i, input logic [63:0] a, input logic [31:0] l, output int acc_cyc);
    logic [NREQ-1:0] got;
    req_addr[i*64 +: 64] = a;
    req_len[i*32 +: 32]  = l;
    req_valid[i]         = 1'b1;
    for (int k = 0; k < 60 && acc_q.size() == 0; k++) tick();
    req_valid[i] = 1'b0;
    got     = (acc_q.size() != 0) ? acc_q.pop_front() : '0;
    acc_cyc = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : 0;
    check($sformatf("accept_req%0d", i), 128'(got), 128'(1 << i));
  endtask

  task automatic wait_cmds(input string tag, input int n);
    for (int k = 0; k < 100 && cmd_q.size() < n; k++) tick();
    check(tag, 128'(cmd_q.size()), 128'(n));
  endtask

  task automatic expect_cmd(input string tag, input logic [103:0] exp);
    logic [103:0] got;
    got = (cmd_q.size() != 0) ? cmd_q.pop_front() : '0;
    check(tag, 128'(got), 128'(exp));
  endtask

  task automatic send_sts(input logic [7:0] d);
    sts_tvalid = 1'b1;
    sts_tdata  = d;
    tick();
    sts_tvalid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input int id, input logic e, output int dcyc);
    logic [NREQ-1:0] gd, ge;
    for (int k = 0; k < 100 && done_q.size() == 0; k++) tick();
    gd   = (done_q.size() != 0) ? done_q.pop_front() : '0;
    ge   = (derr_q.size() != 0) ? derr_q.pop_front() : '0;
    dcyc = (done_cyc_q.size() != 0) ? done_cyc_q.pop_front() : 0;
    check({tag, "_done"}, 128'(gd), 128'(1 << id));
    check({tag, "_err"}, 128'(ge), 128'(e ? (1 << id) : 0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ac, dc;
    axis_rst   = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_len    = '0;
    cmd_tready = 1'b1;
    sts_tdata  = '0;
    sts_tvalid = 1'b0;
    sts_tlast  = 1'b1;
    repeat (3) tick();
    axis_rst = 1'b0;
    tick();
    check("rst_state", 128'({req_ready, done, err, busy, cmd_tvalid, grant_id}), 128'(0));
    check("sts_tready", 128'(sts_tready), 128'(1));

    // Aligned job on requester 0
    start_job(0, 64'h1000_0000, 32'h3000, ac);
    wait_cmds("t1_ncmd", 3);
    expect_cmd("t1_cmd0", mkcmd(23'h1000, 1'b0, 64'h1000_0000, 4'd0));
    expect_cmd("t1_cmd1", mkcmd(23'h1000, 1'b0, 64'h1000_1000, 4'd0));
    expect_cmd("t1_cmd2", mkcmd(23'h1000, 1'b1, 64'h1000_2000, 4'd0));
    check("t1_busy", 128'(busy), 128'(1));
    repeat (3) send_sts(8'h80);
    expect_done("t1", 0, 1'b0, dc);
    check("t1_idle_busy", 128'(busy), 128'(0));

    // Unaligned job, tready held low first to see tdata stay put
    cmd_tready = 1'b0;
    start_job(1, 64'h2000_0F00, 32'h1200, ac);
    repeat (2) tick();
    check("t2_hold_vld", 128'(cmd_tvalid), 128'(1));
    check("t2_hold_dat0", 128'(cmd_tdata), 128'(mkcmd(23'h100, 1'b0, 64'h2000_0F00, 4'd1)));
    tick();
    check("t2_hold_dat1", 128'(cmd_tdata), 128'(mkcmd(23'h100, 1'b0, 64'h2000_0F00, 4'd1)));
    check("t2_gid", 128'(grant_id), 128'(1));
    cmd_tready = 1'b1;
    wait_cmds("t2_ncmd", 3);
    expect_cmd("t2_cmd0", mkcmd(23'h100, 1'b0, 64'h2000_0F00, 4'd1));
    expect_cmd("t2_cmd1", mkcmd(23'h1000, 1'b0, 64'h2000_1000, 4'd1));
    expect_cmd("t2_cmd2", mkcmd(23'h100, 1'b1, 64'h2000_2000, 4'd1));
    repeat (3) send_sts(8'h81);
    expect_done("t2", 1, 1'b0, dc);

    // Outstanding limit
    start_job(2, 64'h0, 32'h8000, ac);
    wait_cmds("t3_first4", 4);
    repeat (10) tick();
    check("t3_stall_n", 128'(cmd_q.size()), 128'(4));
    check("t3_stall_vld", 128'(cmd_tvalid), 128'(0));
    send_sts(8'h82);
    repeat (5) tick();
    check("t3_release1", 128'(cmd_q.size()), 128'(5));
    repeat (3) send_sts(8'h82);
    repeat (5) tick();
    check("t3_total", 128'(cmd_q.size()), 128'(8));
    for (int k = 0; k < 8; k++)
      expect_cmd($sformatf("t3_cmd%0d", k), mkcmd(23'h1000, (k == 7), 64'(k * 32'h1000), 4'd2));
    repeat (4) send_sts(8'h82);
    expect_done("t3", 2, 1'b0, dc);

    // Round robin with zero-length jobs on req0 and req2 (pointer now at 3)
    req_len[0 +: 32]  = 32'h0;
    req_len[64 +: 32] = 32'h0;
    req_valid = 4'b0101;
    for (int k = 0; k < 60 && acc_q.size() < 4; k++) tick();
    req_valid = '0;
    repeat (6) tick();
    check("t4_naccept", 128'(acc_q.size()), 128'(4));
    for (int k = 0; k < 4; k++) begin
      logic [NREQ-1:0] g;
      g = (acc_q.size() != 0) ? acc_q.pop_front() : '0;
      check($sformatf("t4_grant%0d", k), 128'(g), 128'((k % 2 == 0) ? 4'b0001 : 4'b0100));
    end
    acc_cyc_q.delete();
    for (int k = 0; k < 4; k++)
      expect_done($sformatf("t4_job%0d", k), (k % 2 == 0) ? 0 : 2, 1'b0, dc);
    check("t4_nocmd", 128'(cmd_q.size()), 128'(0));

    // Error cases: SLVERR on second status, then wrong tag, then a clean job
    start_job(1, 64'h0, 32'h2000, ac);
    wait_cmds("t5a_ncmd", 2);
    expect_cmd("t5a_cmd0", mkcmd(23'h1000, 1'b0, 64'h0, 4'd1));
    expect_cmd("t5a_cmd1", mkcmd(23'h1000, 1'b1, 64'h1000, 4'd1));
    send_sts(8'h81);
    send_sts(8'h41);
    expect_done("t5a", 1, 1'b1, dc);
    start_job(3, 64'h5000, 32'h1000, ac);
    wait_cmds("t5b_ncmd", 1);
    expect_cmd("t5b_cmd0", mkcmd(23'h1000, 1'b1, 64'h5000, 4'd3));
    send_sts(8'h80);
    expect_done("t5b", 3, 1'b1, dc);
    start_job(0, 64'h6000, 32'h1000, ac);
    wait_cmds("t5c_ncmd", 1);
    expect_cmd("t5c_cmd0", mkcmd(23'h1000, 1'b1, 64'h6000, 4'd0));
    send_sts(8'h80);
    expect_done("t5c", 0, 1'b0, dc);
    start_job(2, 64'h7000, 32'h0, ac);
    expect_done("t5d", 2, 1'b0, dc);
    check("t5d_latency", 128'(dc - ac), 128'(2));
    check("t5d_nocmd", 128'(cmd_q.size()), 128'(0));

    // Address wrap across 2^64
    start_job(3, 64'hFFFF_FFFF_FFFF_FF80, 32'h100, ac);
    wait_cmds("t5e_ncmd", 2);
    expect_cmd("t5e_cmd0", mkcmd(23'h80, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 4'd3));
    expect_cmd("t5e_cmd1", mkcmd(23'h80, 1'b1, 64'h0, 4'd3));
    repeat (2) send_sts(8'h83);
    expect_done("t5e", 3, 1'b0, dc);

    // Reset mid-job after two commands
    start_job(0, 64'h0, 32'h4000, ac);
    for (int k = 0; k < 50 && cmd_q.size() < 2; k++) tick();
    cmd_tready = 1'b0;
    check("t6_two_cmds", 128'(cmd_q.size()), 128'(2));
    cmd_q.delete();
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    check("t6_vld_after_rst", 128'(cmd_tvalid), 128'(0));
    check("t6_busy_after_rst", 128'(busy), 128'(0));
    check("t6_gid_after_rst", 128'(grant_id), 128'(0));
    send_sts(8'h80);
    repeat (4) tick();
    check("t6_no_done", 128'(done_q.size()), 128'(0));
    cmd_tready = 1'b1;
    start_job(0, 64'h3000, 32'h1000, ac);
    wait_cmds("t6_new_ncmd", 1);
    expect_cmd("t6_new_cmd0", mkcmd(23'h1000, 1'b1, 64'h3000, 4'd0));
    send_sts(8'h80);
    expect_done("t6_new", 0, 1'b0, dc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
